pkt_rr_sched: RTL

- Round-robin packet scheduler that shares one output packet bus among NCH upstream packet buffers.
- Each upstream buffer is a data FIFO plus a length (message) FIFO, both show-ahead.
- The block picks a channel at packet boundaries, pops exactly the stored packet length from that channel's data FIFO, and emits it with sop/eop/vld framing and a source tag.
- It sits between the per-port ingress packet FIFOs and the downstream framer/splitter.

---
 rtl/pkt_rr_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pkt_rr_sched.sv
// rtl/pkt_rr_sched.sv - round-robin packet scheduler sharing one output bus among NCH packet buffers
module pkt_rr_sched #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int LW  = 16,
    parameter int CW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_msg_empty,
    input  logic [NCH*LW-1:0] ch_msg_q,
    output logic [NCH-1:0]    ch_msg_rdreq,
    input  logic [NCH-1:0]    ch_data_empty,
    input  logic [NCH*DW-1:0] ch_data_q,
    output logic [NCH-1:0]    ch_data_rdreq,
    input  logic              out_rdy,
    output logic [DW-1:0]     dout,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [CW-1:0]     dout_ch
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rr_q, rr_d;
    logic [CW-1:0] grant_q, grant_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic [CW-1:0] ch_q, ch_d;

    logic          arb_found;
    logic [CW-1:0] arb_idx;
    logic [LW-1:0] arb_len;
    logic [DW-1:0] sel_data;
    logic          sel_data_empty;
    logic          pop;
    logic          msg_pop;
    logic          last_word;
    logic [CW-1:0] next_rr;

    // First requester at or after the rr pointer; second pass covers the wrap below the pointer
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_len   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!arb_found && !ch_msg_empty[i] && (CW'(i) >= rr_q)) begin
                arb_found = 1'b1;
                arb_idx   = CW'(i);
                arb_len   = ch_msg_q[i*LW +: LW];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!arb_found && !ch_msg_empty[i]) begin
                arb_found = 1'b1;
                arb_idx   = CW'(i);
                arb_len   = ch_msg_q[i*LW +: LW];
            end
        end
    end

    // Head data word and empty flag of the granted channel
    always_comb begin
        sel_data       = '0;
        sel_data_empty = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (grant_q == CW'(i)) begin
                sel_data       = ch_data_q[i*DW +: DW];
                sel_data_empty = ch_data_empty[i];
            end
        end
    end

    assign next_rr   = (grant_q == CW'(NCH-1)) ? '0 : grant_q + 1'b1;
    assign last_word = (cnt_q == len_q - LW'(1));

    // Next state, FIFO pops and the registered output word
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        ch_d    = grant_q;
        pop     = 1'b0;
        msg_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    len_d   = arb_len;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (len_q == '0) begin
                    // empty descriptor: retire it without touching the data FIFO
                    msg_pop = 1'b1;
                    rr_d    = next_rr;
                    state_d = S_IDLE;
                end else if (out_rdy && !sel_data_empty) begin
                    pop    = 1'b1;
                    cnt_d  = cnt_q + LW'(1);
                    dout_d = sel_data;
                    vld_d  = 1'b1;
                    sop_d  = (cnt_q == '0);
                    eop_d  = last_word;
                    if (last_word) begin
                        msg_pop = 1'b1;
                        rr_d    = next_rr;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        for (int i = 0; i < NCH; i++) begin
            ch_data_rdreq[i] = pop && (grant_q == CW'(i));
            ch_msg_rdreq[i]  = msg_pop && (grant_q == CW'(i));
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            ch_q    <= ch_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign dout_sop = sop_q;
    assign dout_eop = eop_q;
    assign dout_ch  = ch_q;

endmodule
